// File: rtl/alu_reservation_station.sv
// ALU reservation station: a collapsing queue of dispatched ALU ops that
// captures missing operands (A, B, flags) from the CDB by tag and issues the
// oldest fully-ready op to the execute unit over a valid/ready handshake.
module alu_reservation_station #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 4,
    parameter int DATA_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    // dispatch
    input  logic              disp_valid_i,
    output logic              disp_ready_o,
    input  logic [4:0]        disp_alu_op_i,
    input  logic              disp_a_rdy_i,
    input  logic [TAG_W-1:0]  disp_a_tag_i,
    input  logic [DATA_W-1:0] disp_a_val_i,
    input  logic              disp_b_rdy_i,
    input  logic [TAG_W-1:0]  disp_b_tag_i,
    input  logic [DATA_W-1:0] disp_b_val_i,
    input  logic              disp_cc_rdy_i,
    input  logic [TAG_W-1:0]  disp_cc_tag_i,
    input  logic [3:0]        disp_nzcv_i,
    input  logic [5:0]        disp_valhw_i,
    input  logic              disp_set_cc_i,
    input  logic [3:0]        disp_cond_i,
    input  logic [TAG_W-1:0]  disp_dst_tag_i,
    // common data bus
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_val_i,
    input  logic              cdb_cc_valid_i,
    input  logic [3:0]        cdb_nzcv_i,
    // issue
    output logic              iss_valid_o,
    input  logic              iss_ready_i,
    output logic [4:0]        iss_alu_op_o,
    output logic [DATA_W-1:0] iss_vala_o,
    output logic [DATA_W-1:0] iss_valb_o,
    output logic [5:0]        iss_valhw_o,
    output logic              iss_set_cc_o,
    output logic [3:0]        iss_cond_o,
    output logic [3:0]        iss_nzcv_o,
    output logic [TAG_W-1:0]  iss_dst_tag_o
);

    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_ENTRIES);

    typedef struct packed {
        logic              valid;
        logic [4:0]        alu_op;
        logic              a_rdy;
        logic [TAG_W-1:0]  a_tag;
        logic [DATA_W-1:0] a_val;
        logic              b_rdy;
        logic [TAG_W-1:0]  b_tag;
        logic [DATA_W-1:0] b_val;
        logic              cc_rdy;
        logic [TAG_W-1:0]  cc_tag;
        logic [3:0]        nzcv;
        logic [5:0]        valhw;
        logic              set_cc;
        logic [3:0]        cond;
        logic [TAG_W-1:0]  dst_tag;
    } entry_t;

    entry_t             entries_q   [NUM_ENTRIES];
    entry_t             entries_d   [NUM_ENTRIES];
    entry_t             entries_ext [NUM_ENTRIES+1];
    entry_t             new_entry;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_ENTRIES-1:0] eligible;
    logic               disp_fire, issue_fire;

    // Capture any still-missing operand whose producer tag is on the CDB this cycle.
    function automatic entry_t wake(input entry_t e, input logic cv, input logic [TAG_W-1:0] ct,
                                    input logic [DATA_W-1:0] cval, input logic ccv,
                                    input logic [3:0] cnzcv);
        entry_t r;
        r = e;
        if (e.valid && cv) begin
            if (!e.a_rdy && e.a_tag == ct) begin
                r.a_rdy = 1'b1;
                r.a_val = cval;
            end
            if (!e.b_rdy && e.b_tag == ct) begin
                r.b_rdy = 1'b1;
                r.b_val = cval;
            end
            if (!e.cc_rdy && ccv && e.cc_tag == ct) begin
                r.cc_rdy = 1'b1;
                r.nzcv   = cnzcv;
            end
        end
        return r;
    endfunction

    assign disp_ready_o = (count_q < FULL);
    assign disp_fire    = disp_valid_i & disp_ready_o;
    assign issue_fire   = iss_valid_o & iss_ready_i;
    assign wr_idx       = count_q - CNT_W'(issue_fire);

    // Oldest-first select: scan from the top down so the lowest eligible index wins.
    always_comb begin
        iss_valid_o = 1'b0;
        sel_idx     = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            eligible[i] = entries_q[i].valid & entries_q[i].a_rdy &
                          entries_q[i].b_rdy & entries_q[i].cc_rdy;
            if (eligible[i]) begin
                iss_valid_o = 1'b1;
                sel_idx     = IDX_W'(i);
            end
        end
    end

    // Present the selected entry; every field reads as zero while nothing is valid.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        iss_alu_op_o  = '0;
        iss_vala_o    = '0;
        iss_valb_o    = '0;
        iss_valhw_o   = '0;
        iss_set_cc_o  = 1'b0;
        iss_cond_o    = '0;
        iss_nzcv_o    = '0;
        iss_dst_tag_o = '0;
        if (iss_valid_o) begin
            iss_alu_op_o  = entries_q[sel_idx].alu_op;
            iss_vala_o    = entries_q[sel_idx].a_val;
            iss_valb_o    = entries_q[sel_idx].b_val;
            iss_valhw_o   = entries_q[sel_idx].valhw;
            iss_set_cc_o  = entries_q[sel_idx].set_cc;
            iss_cond_o    = entries_q[sel_idx].cond;
            iss_nzcv_o    = entries_q[sel_idx].nzcv;
            iss_dst_tag_o = entries_q[sel_idx].dst_tag;
        end
    end

    // Next queue contents: collapse over the issued slot, apply wakeup, append the dispatch.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) entries_ext[i] = entries_q[i];
        entries_ext[NUM_ENTRIES] = '0;

        new_entry.valid   = 1'b1;
        new_entry.alu_op  = disp_alu_op_i;
        new_entry.a_rdy   = disp_a_rdy_i;
        new_entry.a_tag   = disp_a_tag_i;
        new_entry.a_val   = disp_a_val_i;
        new_entry.b_rdy   = disp_b_rdy_i;
        new_entry.b_tag   = disp_b_tag_i;
        new_entry.b_val   = disp_b_val_i;
        new_entry.cc_rdy  = disp_cc_rdy_i;
        new_entry.cc_tag  = disp_cc_tag_i;
        new_entry.nzcv    = disp_nzcv_i;
        new_entry.valhw   = disp_valhw_i;
        new_entry.set_cc  = disp_set_cc_i;
        new_entry.cond    = disp_cond_i;
        new_entry.dst_tag = disp_dst_tag_i;
        // Bypass: a dispatching op sees the live CDB exactly like a resident entry.
        new_entry = wake(new_entry, cdb_valid_i, cdb_tag_i, cdb_val_i, cdb_cc_valid_i, cdb_nzcv_i);

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (issue_fire && i >= int'(sel_idx))
                entries_d[i] = wake(entries_ext[i+1], cdb_valid_i, cdb_tag_i, cdb_val_i,
                                    cdb_cc_valid_i, cdb_nzcv_i);
            else
                entries_d[i] = wake(entries_ext[i], cdb_valid_i, cdb_tag_i, cdb_val_i,
                                    cdb_cc_valid_i, cdb_nzcv_i);
            if (disp_fire && i == int'(wr_idx))
                entries_d[i] = new_entry;
        end

        count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);

        if (flush_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entries_d[i] = '0;
            count_d = '0;
        end
    end

    // State registers; reset empties the station immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the whole entry array is reset (not just valid bits) so issue fields read zero and no X ever escapes.
            for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= entries_d[i];
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed testbench for alu_reservation_station with hand-computed expectations.
module tb_alu_reservation_station;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              disp_valid_i;
    logic              disp_ready_o;
    logic [4:0]        disp_alu_op_i;
    logic              disp_a_rdy_i;
    logic [TAG_W-1:0]  disp_a_tag_i;
    logic [DATA_W-1:0] disp_a_val_i;
    logic              disp_b_rdy_i;
    logic [TAG_W-1:0]  disp_b_tag_i;
    logic [DATA_W-1:0] disp_b_val_i;
    logic              disp_cc_rdy_i;
    logic [TAG_W-1:0]  disp_cc_tag_i;
    logic [3:0]        disp_nzcv_i;
    logic [5:0]        disp_valhw_i;
    logic              disp_set_cc_i;
    logic [3:0]        disp_cond_i;
    logic [TAG_W-1:0]  disp_dst_tag_i;
    logic              cdb_valid_i;
    logic [TAG_W-1:0]  cdb_tag_i;
    logic [DATA_W-1:0] cdb_val_i;
    logic              cdb_cc_valid_i;
    logic [3:0]        cdb_nzcv_i;
    logic              iss_valid_o;
    logic              iss_ready_i;
    logic [4:0]        iss_alu_op_o;
    logic [DATA_W-1:0] iss_vala_o;
    logic [DATA_W-1:0] iss_valb_o;
    logic [5:0]        iss_valhw_o;
    logic              iss_set_cc_o;
    logic [3:0]        iss_cond_o;
    logic [3:0]        iss_nzcv_o;
    logic [TAG_W-1:0]  iss_dst_tag_o;

    int checks = 0;
    int errors = 0;

    alu_reservation_station #(.NUM_ENTRIES(4), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_alu_op_i(disp_alu_op_i),
        .disp_a_rdy_i(disp_a_rdy_i), .disp_a_tag_i(disp_a_tag_i), .disp_a_val_i(disp_a_val_i),
        .disp_b_rdy_i(disp_b_rdy_i), .disp_b_tag_i(disp_b_tag_i), .disp_b_val_i(disp_b_val_i),
        .disp_cc_rdy_i(disp_cc_rdy_i), .disp_cc_tag_i(disp_cc_tag_i), .disp_nzcv_i(disp_nzcv_i),
        .disp_valhw_i(disp_valhw_i), .disp_set_cc_i(disp_set_cc_i), .disp_cond_i(disp_cond_i),
        .disp_dst_tag_i(disp_dst_tag_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_val_i(cdb_val_i),
        .cdb_cc_valid_i(cdb_cc_valid_i), .cdb_nzcv_i(cdb_nzcv_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i), .iss_alu_op_o(iss_alu_op_o),
        .iss_vala_o(iss_vala_o), .iss_valb_o(iss_valb_o), .iss_valhw_o(iss_valhw_o),
        .iss_set_cc_o(iss_set_cc_o), .iss_cond_o(iss_cond_o), .iss_nzcv_o(iss_nzcv_o),
        .iss_dst_tag_o(iss_dst_tag_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i = 0; disp_valid_i = 0; disp_alu_op_i = 0;
        disp_a_rdy_i = 0; disp_a_tag_i = 0; disp_a_val_i = 0;
        disp_b_rdy_i = 0; disp_b_tag_i = 0; disp_b_val_i = 0;
        disp_cc_rdy_i = 0; disp_cc_tag_i = 0; disp_nzcv_i = 0;
        disp_valhw_i = 0; disp_set_cc_i = 0; disp_cond_i = 0; disp_dst_tag_i = 0;
        cdb_valid_i = 0; cdb_tag_i = 0; cdb_val_i = 0; cdb_cc_valid_i = 0; cdb_nzcv_i = 0;
    endtask

    task automatic disp(input logic ar, input logic [3:0] at, input logic [63:0] av,
                        input logic br, input logic [3:0] bt, input logic [63:0] bv,
                        input logic cr, input logic [3:0] ct, input logic [3:0] nz,
                        input logic [3:0] dst);
        disp_valid_i = 1;
        disp_a_rdy_i = ar;  disp_a_tag_i = at;  disp_a_val_i = av;
        disp_b_rdy_i = br;  disp_b_tag_i = bt;  disp_b_val_i = bv;
        disp_cc_rdy_i = cr; disp_cc_tag_i = ct; disp_nzcv_i = nz;
        disp_dst_tag_i = dst;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [63:0] v, input logic ccv, input logic [3:0] nz);
        cdb_valid_i = 1; cdb_tag_i = t; cdb_val_i = v; cdb_cc_valid_i = ccv; cdb_nzcv_i = nz;
    endtask

    initial begin
        idle();
        iss_ready_i = 0;
        rst = 1;
        #2;
        check("rst_iss_valid", 64'(iss_valid_o), 64'd0);
        check("rst_disp_ready", 64'(disp_ready_o), 64'd1);
        check("rst_iss_vala", iss_vala_o, 64'd0);
        step();
        rst = 0;
        step();

        // Ready dispatch: all operands ready, pass-through fields intact, 1-cycle latency.
        disp(1, 0, 64'd5, 1, 0, 64'd7, 1, 0, 4'h6, 4'd3);
        disp_alu_op_i = 5'd2; disp_valhw_i = 6'd33; disp_set_cc_i = 1; disp_cond_i = 4'hB;
        step();
        idle();
        check("rdy_iss_valid", 64'(iss_valid_o), 64'd1);
        check("rdy_vala", iss_vala_o, 64'd5);
        check("rdy_valb", iss_valb_o, 64'd7);
        check("rdy_dst", 64'(iss_dst_tag_o), 64'd3);
        check("rdy_alu_op", 64'(iss_alu_op_o), 64'd2);
        check("rdy_valhw", 64'(iss_valhw_o), 64'd33);
        check("rdy_set_cc", 64'(iss_set_cc_o), 64'd1);
        check("rdy_cond", 64'(iss_cond_o), 64'hB);
        check("rdy_nzcv", 64'(iss_nzcv_o), 64'h6);
        iss_ready_i = 1;
        step();
        iss_ready_i = 0;
        check("rdy_empty_after", 64'(iss_valid_o), 64'd0);
        check("rdy_zero_after", 64'(iss_dst_tag_o), 64'd0);

        // Wakeup of B from CDB; becomes issuable only the cycle after the broadcast.
        disp(1, 0, 64'd1, 0, 4'd2, 64'd0, 1, 0, 0, 4'd4);
        step();
        idle();
        check("wk_wait_valid", 64'(iss_valid_o), 64'd0);
        cdb(4'd2, 64'h10, 0, 0);
        #1;
        check("wk_same_cycle_valid", 64'(iss_valid_o), 64'd0);
        step();
        idle();
        check("wk_valid", 64'(iss_valid_o), 64'd1);
        check("wk_valb", iss_valb_o, 64'h10);
        iss_ready_i = 1;
        step();
        iss_ready_i = 0;

        // Bypass: operand A captured from the CDB in the dispatch cycle.
        disp(0, 4'd6, 64'd0, 1, 0, 64'd9, 1, 0, 0, 4'd5);
        cdb(4'd6, 64'hAA, 0, 0);
        step();
        idle();
        check("byp_valid", 64'(iss_valid_o), 64'd1);
        check("byp_vala", iss_vala_o, 64'hAA);
        iss_ready_i = 1;
        step();
        iss_ready_i = 0;

        // A and B on the same tag both captured.
        disp(0, 4'd7, 64'd0, 0, 4'd7, 64'd0, 1, 0, 0, 4'd6);
        step();
        idle();
        cdb(4'd7, 64'h77, 0, 0);
        step();
        idle();
        check("ab_vala", iss_vala_o, 64'h77);
        check("ab_valb", iss_valb_o, 64'h77);
        iss_ready_i = 1;
        step();
        iss_ready_i = 0;

        // Flags operand wakes only with cdb_cc_valid.
        disp(1, 0, 64'd1, 1, 0, 64'd2, 0, 4'd5, 0, 4'd7);
        step();
        idle();
        cdb(4'd5, 64'h55, 0, 4'h3);
        step();
        idle();
        check("cc_no_ccvalid", 64'(iss_valid_o), 64'd0);
        cdb(4'd5, 64'h55, 1, 4'hA);
        step();
        idle();
        check("cc_valid", 64'(iss_valid_o), 64'd1);
        check("cc_nzcv", 64'(iss_nzcv_o), 64'hA);
        iss_ready_i = 1;
        step();
        iss_ready_i = 0;
        check("cc_empty", 64'(iss_valid_o), 64'd0);

        // Order/full: four waiting ops (tags 1..4), woken youngest first.
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("fill_ready_%0d", k), 64'(disp_ready_o), 64'd1);
            disp(0, 4'(k), 64'd0, 1, 0, 64'd0, 1, 0, 0, 4'(8 + k));
            step();
        end
        idle();
        check("full_disp_ready", 64'(disp_ready_o), 64'd0);
        check("full_iss_valid", 64'(iss_valid_o), 64'd0);
        for (int k = 4; k >= 1; k--) begin
            cdb(4'(k), 64'(k * 17), 0, 0);
            step();
            idle();
            check($sformatf("preempt_dst_%0d", k), 64'(iss_dst_tag_o), 64'(8 + k));
            check($sformatf("preempt_vala_%0d", k), iss_vala_o, 64'(k * 17));
        end
        // Issue and dispatch attempt together at full: dispatch refused.
        iss_ready_i = 1;
        disp(1, 0, 64'd0, 1, 0, 64'd0, 1, 0, 0, 4'd15);
        #1;
        check("full_issue_disp_ready", 64'(disp_ready_o), 64'd0);
        step();
        idle();
        check("after_full_disp_ready", 64'(disp_ready_o), 64'd1);
        for (int k = 2; k <= 4; k++) begin
            check($sformatf("order_dst_%0d", k), 64'(iss_dst_tag_o), 64'(8 + k));
            step();
        end
        iss_ready_i = 0;
        check("order_drained", 64'(iss_valid_o), 64'd0);

        // Flush overrides dispatch and a CDB hit in the same cycle.
        disp(0, 4'd1, 64'd0, 1, 0, 64'd0, 1, 0, 0, 4'd1);
        step();
        disp(0, 4'd2, 64'd0, 1, 0, 64'd0, 1, 0, 0, 4'd2);
        step();
        disp(1, 0, 64'd3, 1, 0, 64'd3, 1, 0, 0, 4'd3);
        cdb(4'd1, 64'h99, 0, 0);
        flush_i = 1;
        step();
        idle();
        check("flush_iss_valid", 64'(iss_valid_o), 64'd0);
        check("flush_disp_ready", 64'(disp_ready_o), 64'd1);
        cdb(4'd2, 64'h22, 0, 0);
        step();
        idle();
        check("flush_no_stale", 64'(iss_valid_o), 64'd0);

        // Asynchronous reset mid-operation with 3 entries held.
        disp(1, 0, 64'd1, 1, 0, 64'd1, 1, 0, 0, 4'd1);
        step();
        disp(0, 4'd3, 64'd0, 1, 0, 64'd0, 1, 0, 0, 4'd2);
        step();
        disp(0, 4'd4, 64'd0, 1, 0, 64'd0, 1, 0, 0, 4'd3);
        step();
        idle();
        check("pre_rst_iss_valid", 64'(iss_valid_o), 64'd1);
        #2;
        rst = 1;
        #1;
        check("mid_rst_iss_valid", 64'(iss_valid_o), 64'd0);
        check("mid_rst_disp_ready", 64'(disp_ready_o), 64'd1);
        #1;
        rst = 0;
        step();
        // Count must restart at 0: exactly four more dispatches fill the station.
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("post_rst_ready_%0d", k), 64'(disp_ready_o), 64'd1);
            disp(0, 4'd9, 64'd0, 1, 0, 64'd0, 1, 0, 0, 4'(k));
            step();
        end
        idle();
        check("post_rst_full", 64'(disp_ready_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
